uart_bram_cmd_master: RTL

//  Host-side initiator for the UART BRAM command protocol: turns local requests into READ (0x11),

---
 rtl/uart_bram_cmd_master.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_bram_cmd_master.sv
// Host-side initiator for the UART BRAM command protocol: issues READ/WRITE/ERASE byte
// sequences on a UART transmitter and streams READ response bytes back from the receiver.
module uart_bram_cmd_master #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned SIZE       = 4096,
  parameter int unsigned CNT_WIDTH  = 12,
  parameter int unsigned RD_TIMEOUT = 1000000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [1:0]            i_cmd_op,
  input  logic                  i_wr_valid,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_wr_last,
  output logic                  o_wr_ready,
  output logic                  o_tx_start,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  input  logic                  i_tx_busy,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic                  i_rx_done,
  output logic                  o_rd_valid,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  output logic [CNT_WIDTH-1:0]  o_byte_count
);

  localparam int unsigned TimerW = $clog2(RD_TIMEOUT + 1);
  localparam logic [CNT_WIDTH-1:0] LastCnt = CNT_WIDTH'(SIZE - 1);
  localparam logic [TimerW-1:0] TimerLimit = TimerW'(RD_TIMEOUT - 1);

  localparam logic [1:0] OpRsvd  = 2'b00;
  localparam logic [1:0] OpRead  = 2'b01;
  localparam logic [1:0] OpWrite = 2'b10;

  localparam logic [DATA_WIDTH-1:0] ByteRead  = DATA_WIDTH'(8'h11);
  localparam logic [DATA_WIDTH-1:0] ByteWrite = DATA_WIDTH'(8'h12);
  localparam logic [DATA_WIDTH-1:0] ByteErase = DATA_WIDTH'(8'h13);
  localparam logic [DATA_WIDTH-1:0] ByteEsc   = DATA_WIDTH'(8'h1B);

  typedef enum logic [2:0] {
    StIdle, StSend, StTxHi, StTxLo, StWrFetch, StRdCollect, StDone
  } state_e;

  // Which byte of the command is in flight, so TX_LO knows where to go next.
  typedef enum logic [1:0] {PhCmd, PhPayload, PhEsc} phase_e;

  state_e                  r_state, w_state_d;
  phase_e                  r_phase, w_phase_d;
  logic [1:0]              r_op, w_op_d;
  logic [DATA_WIDTH-1:0]   r_tx_data, w_tx_data_d;
  logic                    r_last, w_last_d;
  logic [CNT_WIDTH-1:0]    r_cnt, w_cnt_d;
  logic                    r_error, w_error_d;
  logic [TimerW-1:0]       r_timer, w_timer_d;
  logic                    r_rx_q, r_rx_qq;
  logic [DATA_WIDTH-1:0]   r_rx_data;

  logic                    w_tx_start, w_wr_ready, w_rd_valid, w_done;
  logic                    w_rx_rise;
  logic [CNT_WIDTH-1:0]    w_cnt_inc;

  assign w_rx_rise = r_rx_q & ~r_rx_qq;
  assign w_cnt_inc = r_cnt + CNT_WIDTH'(1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_phase   <= PhCmd;
      r_op      <= OpRsvd;
      r_tx_data <= '0;
      r_last    <= 1'b0;
      r_cnt     <= '0;
      r_error   <= 1'b0;
      r_timer   <= '0;
      r_rx_q    <= 1'b0;
      r_rx_qq   <= 1'b0;
      r_rx_data <= '0;
    end else begin
      r_state   <= w_state_d;
      r_phase   <= w_phase_d;
      r_op      <= w_op_d;
      r_tx_data <= w_tx_data_d;
      r_last    <= w_last_d;
      r_cnt     <= w_cnt_d;
      r_error   <= w_error_d;
      r_timer   <= w_timer_d;
      r_rx_q    <= i_rx_done;
      r_rx_qq   <= r_rx_q;
      if (i_rx_done) begin
        r_rx_data <= i_rx_data;
      end
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_phase_d   = r_phase;
    w_op_d      = r_op;
    w_tx_data_d = r_tx_data;
    w_last_d    = r_last;
    w_cnt_d     = r_cnt;
    w_error_d   = r_error;
    w_timer_d   = r_timer;
    w_tx_start  = 1'b0;
    w_wr_ready  = 1'b0;
    w_rd_valid  = 1'b0;
    w_done      = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (i_cmd_valid) begin
          w_op_d    = i_cmd_op;
          w_cnt_d   = '0;
          w_error_d = 1'b0;
          w_phase_d = PhCmd;
          case (i_cmd_op)
            OpRead:  w_tx_data_d = ByteRead;
            OpWrite: w_tx_data_d = ByteWrite;
            default: w_tx_data_d = ByteErase;
          endcase
          if (i_cmd_op == OpRsvd) begin
            w_error_d = 1'b1;
            w_state_d = StDone;
          end else begin
            w_state_d = StSend;
          end
        end
      end
      StSend: begin
        if (!i_tx_busy) begin
          w_tx_start = 1'b1;
          w_state_d  = StTxHi;
        end
      end
      StTxHi: begin
        if (i_tx_busy) begin
          w_state_d = StTxLo;
        end
      end
      StTxLo: begin
        if (!i_tx_busy) begin
          unique case (r_phase)
            PhCmd: begin
              case (r_op)
                OpRead: begin
                  w_state_d = StRdCollect;
                  w_timer_d = TimerW'(1);
                end
                OpWrite: w_state_d = StWrFetch;
                default: w_state_d = StDone;
              endcase
            end
            PhPayload: begin
              // A full payload makes the remote leave write mode by itself, so no ESC.
              if (r_cnt == LastCnt) begin
                w_state_d = StDone;
              end else if (r_last) begin
                w_tx_data_d = ByteEsc;
                w_phase_d   = PhEsc;
                w_state_d   = StSend;
              end else begin
                w_state_d = StWrFetch;
              end
            end
            default: w_state_d = StDone;
          endcase
        end
      end
      StWrFetch: begin
        if (i_wr_valid) begin
          w_wr_ready  = 1'b1;
          w_tx_data_d = i_wr_data;
          w_last_d    = i_wr_last;
          w_cnt_d     = w_cnt_inc;
          w_phase_d   = PhPayload;
          w_state_d   = StSend;
        end
      end
      StRdCollect: begin
        if (w_rx_rise) begin
          w_rd_valid = 1'b1;
          w_cnt_d    = w_cnt_inc;
          w_timer_d  = TimerW'(1);
          if (w_cnt_inc == LastCnt) begin
            w_state_d = StDone;
          end
        end else if (r_timer >= TimerLimit) begin
          w_error_d = 1'b1;
          w_state_d = StDone;
        end else begin
          w_timer_d = r_timer + TimerW'(1);
        end
      end
      StDone: begin
        w_done    = 1'b1;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign o_cmd_ready  = (r_state == StIdle);
  assign o_busy       = (r_state != StIdle);
  assign o_wr_ready   = w_wr_ready;
  assign o_tx_start   = w_tx_start;
  assign o_tx_data    = r_tx_data;
  assign o_rd_valid   = w_rd_valid;
  assign o_rd_data    = r_rx_data;
  assign o_done       = w_done;
  assign o_error      = r_error;
  assign o_byte_count = r_cnt;

endmodule
